// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and frame constants.
// Used by uart_tx_buffered and reusable by the receive path.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_FIFO_DEPTH   = 16;

  // PARITY is only entered when the design is built with UART_TX_PARITY_EN.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Fabric-side write port and status/serial outputs of the buffered UART transmitter.
// The master side enqueues bytes; the slave side is the transmitter itself.
interface uart_tx_buffered_if import uart_pkg::*; #(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) ();

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                      wr_dv;
  logic [UART_DATA_BITS-1:0] wr_byte;
  logic                      full;
  logic                      empty;
  logic [CW-1:0]             count;
  logic                      overflow;
  logic                      tx_active;
  logic                      tx_serial;
  logic                      tx_done;

  modport master (
    output wr_dv, wr_byte,
    input  full, empty, count, overflow, tx_active, tx_serial, tx_done
  );

  modport slave (
    input  wr_dv, wr_byte,
    output full, empty, count, overflow, tx_active, tx_serial, tx_done
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty/count flags.
// A push while full is dropped even when a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_next;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + 1'b1;
    else if (pop_ok && !push_ok)
      count_next = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding a back-to-back 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_buffered import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input logic               i_Clk,
  input logic               i_Rst,
  uart_tx_buffered_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DONE_TICK = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state;
  logic [CNT_W-1:0]          clk_cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic                      tx_serial;
  logic                      tx_active;
  logic                      tx_done;
  logic                      overflow;

  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic                      tick_last;
  logic                      pop;

  assign tick_last = (clk_cnt == LAST_TICK);
  // A byte leaves the FIFO when idle, or on the last stop cycle to chain frames with no gap.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && tick_last));

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .push    (bus.wr_dv),
    .pop     (pop),
    .wr_data (bus.wr_byte),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      parity_bit <= 1'b0;
    else if (pop)
      parity_bit <= ^fifo_data;
  end
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= bus.wr_dv && fifo_full;
      tx_done  <= (state == STOP) && (clk_cnt == DONE_TICK);
      clk_cnt  <= tick_last ? '0 : clk_cnt + 1'b1;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (pop) begin
            shift_reg <= fifo_data;
            state     <= START;
            tx_serial <= 1'b0;
            tx_active <= 1'b1;
          end
        end
        START: if (tick_last) begin
          state     <= DATA;
          bit_idx   <= '0;
          tx_serial <= shift_reg[0];
        end
        DATA: if (tick_last) begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state     <= PARITY;
            tx_serial <= parity_bit;
`else
            state     <= STOP;
            tx_serial <= 1'b1;
`endif
          end else begin
            bit_idx   <= bit_idx + 1'b1;
            shift_reg <= shift_reg >> 1;
            tx_serial <= shift_reg[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick_last) begin
          state     <= STOP;
          tx_serial <= 1'b1;
        end
`endif
        STOP: if (tick_last) begin
          if (pop) begin
            shift_reg <= fifo_data;
            state     <= START;
            tx_serial <= 1'b0;
          end else begin
            state     <= IDLE;
            tx_active <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.overflow  = overflow;
  assign bus.tx_active = tx_active;
  assign bus.tx_serial = tx_serial;
  assign bus.tx_done   = tx_done;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed tables and sequences plus randomized traffic
// checked every cycle against a frame-position model of the transmitter.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_EN     = 1'b0;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int DONE_CYC  = 1 + FRAME_CYC;
  localparam int HIST      = 8192;
  localparam logic [CW+5:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, {CW{1'b0}}};

  typedef struct {
    int   c;
    logic ser;
    logic act;
    logic done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] q[$];
  bit         m_busy;
  int         m_pos;
  logic [7:0] m_byte;
  bit         m_ovf;

  logic          h_ser  [HIST];
  logic          h_act  [HIST];
  logic          h_done [HIST];
  logic          h_full [HIST];
  logic          h_ovf  [HIST];
  logic [CW-1:0] h_cnt  [HIST];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [CW+5:0] dut_vec();
    return {bus.tx_serial, bus.tx_active, bus.tx_done, bus.full, bus.empty, bus.overflow, bus.count};
  endfunction

  // Expected outputs from the frame position: bit n of the frame is held for CPB cycles.
  function automatic logic [CW+5:0] model_vec();
    logic ser, act, done;
    int   bitn;
    ser  = 1'b1;
    act  = 1'b0;
    done = 1'b0;
    if (m_busy) begin
      act  = 1'b1;
      bitn = m_pos / CPB;
      done = (m_pos == FRAME_CYC - 1);
      if (bitn == 0)                 ser = 1'b0;
      else if (bitn <= 8)            ser = m_byte[bitn-1];
      else if (PAR_EN && bitn == 9)  ser = ^m_byte;
      else                           ser = 1'b1;
    end
    return {ser, act, done, q.size() == DEPTH, q.size() == 0, m_ovf, CW'(q.size())};
  endfunction

  task automatic model_edge(input logic r, input logic dv, input logic [7:0] b);
    bit         popped;
    logic [7:0] pb;
    if (r) begin
      q.delete();
      m_busy = 1'b0;
      m_pos  = 0;
      m_ovf  = 1'b0;
      return;
    end
    popped = (q.size() != 0) && (!m_busy || m_pos == FRAME_CYC - 1);
    m_ovf  = dv && (q.size() == DEPTH);
    pb     = 8'h00;
    if (popped) pb = q.pop_front();
    if (dv && !m_ovf) q.push_back(b);
    if (popped) begin
      m_busy = 1'b1;
      m_pos  = 0;
      m_byte = pb;
    end else if (m_busy) begin
      if (m_pos == FRAME_CYC - 1) m_busy = 1'b0;
      else m_pos++;
    end
  endtask

  task automatic step(input logic r, input logic dv, input logic [7:0] b);
    rst         = r;
    bus.wr_dv   = dv;
    bus.wr_byte = b;
    @(posedge clk);
    model_edge(r, dv, b);
    #1;
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
    h_ser [cyc % HIST] = bus.tx_serial;
    h_act [cyc % HIST] = bus.tx_active;
    h_done[cyc % HIST] = bus.tx_done;
    h_full[cyc % HIST] = bus.full;
    h_ovf [cyc % HIST] = bus.overflow;
    h_cnt [cyc % HIST] = bus.count;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  function automatic int sum_act(input int b, input int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(h_act[(b + i) % HIST]);
    return s;
  endfunction

  function automatic int sum_done(input int b, input int len);
    int s = 0;
    for (int i = 0; i < len; i++) s += int'(h_done[(b + i) % HIST]);
    return s;
  endfunction

  initial begin
    vec_t tbl[15];
    int   base, idx, peak, nd, n, dens;
    int   dpos[3];
    logic fseen;
    logic r, dv;

    // 0xA5 single frame: cycle k counted from the write cycle.
    tbl[0]  = '{1,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{2,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{5,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{6,  1'b1, 1'b1, 1'b0};
    tbl[4]  = '{10, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{14, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{18, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{22, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{26, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{30, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{37, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{38, !PAR_EN, 1'b1, 1'b0};
    tbl[12] = '{DONE_CYC - 1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{DONE_CYC,     1'b1, 1'b1, 1'b1};
    tbl[14] = '{DONE_CYC + 1, 1'b1, 1'b0, 1'b0};

    step(1'b1, 1'b0, 8'h00);
    check("reset_state", 32'(dut_vec()), 32'(RESET_VEC));
    idle(2);

    base = cyc;
    step(1'b0, 1'b1, 8'hA5);
    idle(DONE_CYC + 4);
    for (int i = 0; i < 15; i++) begin
      idx = (base + tbl[i].c - 1) % HIST;
      check($sformatf("a5_c%0d", tbl[i].c), {29'd0, h_ser[idx], h_act[idx], h_done[idx]},
            {29'd0, tbl[i].ser, tbl[i].act, tbl[i].done});
    end
    check("a5_active_len", sum_act(base, DONE_CYC + 4), FRAME_CYC);

    // Three consecutive writes chain into three gap-free frames.
    step(1'b1, 1'b0, 8'h00);
    base = cyc;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h55);
    idle(3 * FRAME_CYC + 10);
    peak = 0;
    nd   = 0;
    for (int i = base; i < cyc; i++) begin
      if (int'(h_cnt[i % HIST]) > peak) peak = int'(h_cnt[i % HIST]);
      if (h_done[i % HIST]) begin
        if (nd < 3) dpos[nd] = i;
        nd++;
      end
    end
    check("burst3_peak_count", peak, 2);
    check("burst3_active_len", sum_act(base, cyc - base), 3 * FRAME_CYC);
    check("burst3_done_count", nd, 3);
    if (nd >= 3) begin
      check("burst3_done_gap1", dpos[1] - dpos[0], FRAME_CYC);
      check("burst3_done_gap2", dpos[2] - dpos[1], FRAME_CYC);
    end

    // Six writes into a 4-deep FIFO: one drops, five frames go out.
    step(1'b1, 1'b0, 8'h00);
    base = cyc;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'(8'h10 + k));
    idle(5 * FRAME_CYC + 10);
    n     = 0;
    fseen = 1'b0;
    for (int i = base; i < cyc; i++) begin
      n += int'(h_ovf[i % HIST]);
      fseen |= h_full[i % HIST];
    end
    check("fill_overflow_pulses", n, 1);
    check("fill_overflow_at", h_ovf[(base + 5) % HIST], 1);
    check("fill_full_seen", fseen, 1);
    check("fill_frames", sum_done(base, cyc - base), 5);

    // Reset during data bit 3 of the first of two queued bytes.
    step(1'b1, 1'b0, 8'h00);
    base = cyc;
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'hC3);
    idle(16);
    check("midrst_in_frame", {h_ser[(base + 17) % HIST], h_act[(base + 17) % HIST]}, 2'b11);
    step(1'b1, 1'b0, 8'h00);
    check("midrst_after", {bus.tx_serial, bus.tx_active, bus.empty}, 3'b101);
    base = cyc;
    idle(2 * FRAME_CYC);
    check("midrst_no_frames", sum_act(base, 2 * FRAME_CYC), 0);

    // Write while full on the same cycle the STOP-end pop frees a slot.
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'(8'h40 + k));
    n = 0;
    while (!bus.tx_done && n < 200) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    check("popfull_done_seen", bus.tx_done, 1);
    check("popfull_full_before", {bus.full, bus.count}, {1'b1, CW'(4)});
    step(1'b0, 1'b1, 8'hEE);
    check("popfull_rejected", {bus.overflow, bus.full, bus.count}, {1'b1, 1'b0, CW'(3)});
    idle(4 * FRAME_CYC + 10);

`ifdef UART_TX_PARITY_EN
    step(1'b1, 1'b0, 8'h00);
    base = cyc;
    step(1'b0, 1'b1, 8'h07);
    idle(50);
    check("parity_07", h_ser[(base + 37) % HIST], 1);
    check("parity_07_len", sum_act(base, 51), 44);
    base = cyc;
    step(1'b0, 1'b1, 8'h03);
    idle(50);
    check("parity_03", h_ser[(base + 37) % HIST], 0);
`endif

    // Randomized traffic: alternating sparse/dense phases with rare resets.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      dens = ((i / 500) % 2 == 1) ? 70 : 2;
      r    = ($urandom_range(599) == 0);
      dv   = ($urandom_range(99) < dens);
      step(r, dv, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Fabric-side UART transmitter with an internal byte FIFO. Logic can write bursts of bytes without waiting on the serial line. The block serialises them 8N1, LSB first, back-to-back on o_Tx_Serial. It is the outbound companion to our UART receiver and replaces direct single-byte transmit handshakes wherever fabric logic originates traffic toward the host.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (i_Clk / baud); must be >= 2.
FIFO_DEPTH, 16, byte entries in FIFO; power of two, >= 2.

Ports:
i_Clk  input  1  main clock
i_Rst  input  1  synchronous active-high reset
i_Wr_DV  input  1  write strobe; byte accepted when high and o_Full low
i_Wr_Byte  input  8  byte to enqueue
o_Full  output  1  FIFO holds FIFO_DEPTH bytes
o_Empty  output  1  FIFO holds no bytes
o_Count  output  $clog2(FIFO_DEPTH+1)  bytes currently queued (excludes byte on the line)
o_Overflow  output  1  1-cycle pulse: write attempted while o_Full
o_Tx_Active  output  1  high from first start-bit cycle through last stop-bit cycle
o_Tx_Serial  output  1  serial line, idles high
o_Tx_Done  output  1  1-cycle pulse on last cycle of each stop bit

Behaviour:
- Reset (i_Rst high at a clock edge):
  - FIFO empty, state IDLE, bit counter and clock counter 0.
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Full=0, o_Empty=1, o_Count=0.
  - Reset mid-frame aborts the frame immediately; the line returns high the next cycle and queued bytes are discarded.
- FIFO:
  - o_Full, o_Empty and o_Count are registered from the occupancy count.
  - Write is accepted iff i_Wr_DV && !o_Full at the edge; a rejected write pulses o_Overflow and leaves the FIFO unchanged.
  - A write while full is rejected even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: line high. If !o_Empty: pop head into shift register, go to START; the start bit appears on the next cycle, so latency from an accepted write into an empty idle block to the line going low is 2 cycles. A write to an empty FIFO cannot pop in the same cycle.
  - START: line 0 for exactly CLKS_PER_BIT cycles, then DATA.
  - DATA: bits 0..7 LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles; o_Tx_Done pulses on the final cycle. On that cycle, if !o_Empty, pop and go directly to START (no idle gap; frame pitch exactly 10*CLKS_PER_BIT). Otherwise go to IDLE.
- o_Tx_Active is high in START, DATA and STOP, including back-to-back transitions.
- The clock counter runs 0..CLKS_PER_BIT-1 and resets on every bit boundary.

Optional Feature:
UART_TX_PARITY_EN defined:
- Adds state PARITY between DATA and STOP, transmitting the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- Frame becomes 8E1; pitch is 11*CLKS_PER_BIT.

Undefined:
- 8N1 as above; no PARITY state or parity logic is present.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP}; PARITY is present but unused without the macro.
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT constant 868.
- Sub-module uart_byte_fifo: parameterised synchronous FIFO (push, pop, data out, full/empty/count). Reusable by the receive path.

Test Plan:
- CLKS_PER_BIT=4, reset, write 0xA5 once -> after 2 cycles line reads 0, then 1,0,1,0,0,1,0,1, then 1 (4 cycles each); o_Tx_Done pulses at cycle 41 after the write; o_Tx_Active high for exactly 40 cycles.
- Write 0x00,0xFF,0x55 on consecutive cycles -> o_Count peaks at 2; three frames with no idle gap (120 cycles of o_Tx_Active); three o_Tx_Done pulses spaced 40 cycles apart.
- FIFO_DEPTH=4, 6 back-to-back writes while idle -> first byte popped and sent; 4 bytes accepted; o_Full asserts; final write pulses o_Overflow once; exactly 5 frames transmitted.
- Assert i_Rst during data bit 3 of the first of two queued bytes -> next cycle o_Tx_Serial=1, o_Tx_Active=0, o_Empty=1; no further frames.
- o_Full asserted, i_Wr_DV high on the same cycle as the STOP-end pop -> write rejected, o_Overflow pulses, o_Count decrements by 1.
- With UART_TX_PARITY_EN, write 0x07 -> parity bit 1 after the data bits, frame 44 cycles; write 0x03 -> parity bit 0.
